// File: rtl/pipeline_dram_responder7_if.sv
// Bus between the pipeline's memory-prepare/memory-data stages and the DRAM responder.
interface pipeline_dram_responder7_if;
   logic [63:0] dram_addr;
   logic [63:0] dram_din;
   logic [2:0]  dram_rd_ctrl;
   logic [2:0]  dram_wr_ctrl;
   logic [63:0] dram_dout;
   logic        dram_dout_valid;
   logic        dram_stall_req;
   logic        dram_misalign;

   modport master (
      output dram_addr, dram_din, dram_rd_ctrl, dram_wr_ctrl,
      input  dram_dout, dram_dout_valid, dram_stall_req, dram_misalign
   );

   modport slave (
      input  dram_addr, dram_din, dram_rd_ctrl, dram_wr_ctrl,
      output dram_dout, dram_dout_valid, dram_stall_req, dram_misalign
   );
endinterface

// File: rtl/pipeline_dram_responder7.sv
// Multi-cycle data DRAM model for the 7-stage pipeline: sized loads/stores with a stall handshake.
//   state | meaning
//   IDLE  | waiting for a request; a request here stalls the pipeline and is latched
//   BUSY  | access in flight, cnt counts remaining cycles down to zero
//   DONE  | result/valid presented for one cycle, stall released
module pipeline_dram_responder7 #(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
   parameter int          LATENCY     = 2
) (
   input logic                        clk,
   input logic                        reset,
   pipeline_dram_responder7_if.slave  dram
);
   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam bit         LAT_ZERO = (LATENCY == 0);
   localparam logic [3:0] CNT_INIT = LAT_ZERO ? 4'd0 : 4'(LATENCY - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] din_q, din_d;
   logic [2:0]  rd_q, rd_d;
   logic [2:0]  wr_q, wr_d;
   logic [63:0] dout_q, dout_d;
   logic        valid_q, valid_d;
   logic        mis_q, mis_d;

   logic [63:0] mem_q [DEPTH_WORDS];

   logic            req;
   logic [63:0]     cur_addr;
   logic [63:0]     cur_din;
   logic [2:0]      cur_rd;
   logic [2:0]      cur_wr;
   logic [63:0]     offset;
   logic [IDX_W-1:0] idx;
   logic [2:0]      lane;
   logic [5:0]      sh;
   logic            err;
   logic            finish;
   logic            we;
   logic [63:0]     word_rd;
   logic [63:0]     word_sh;
   logic [63:0]     load_val;
   logic [63:0]     mask;
   logic [63:0]     mask_sh;
   logic [63:0]     word_wr;

   assign req = (dram.dram_rd_ctrl != 3'd0) || (dram.dram_wr_ctrl != 3'd0);

   // In IDLE the access (LATENCY==0 case) completes off the live inputs; otherwise the latched copy.
   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_addr = dram.dram_addr;
         cur_din  = dram.dram_din;
         cur_rd   = dram.dram_rd_ctrl;
         cur_wr   = dram.dram_wr_ctrl;
      end else begin
         cur_addr = addr_q;
         cur_din  = din_q;
         cur_rd   = rd_q;
         cur_wr   = wr_q;
      end
   end

   assign offset = cur_addr - BASE_ADDR;
   assign idx    = offset[3 +: IDX_W];
   assign lane   = cur_addr[2:0];
   assign sh     = {lane, 3'b000};

   always_comb begin
      err = 1'b0;
      if ((cur_rd != 3'd0) && (cur_wr != 3'd0)) err = 1'b1;
      case (cur_rd)
         3'd3, 3'd4: if (lane[0] != 1'b0)    err = 1'b1;
         3'd5, 3'd6: if (lane[1:0] != 2'b0)  err = 1'b1;
         3'd7:       if (lane != 3'd0)       err = 1'b1;
         default: ;
      endcase
      case (cur_wr)
         3'd2:             if (lane[0] != 1'b0)   err = 1'b1;
         3'd3:             if (lane[1:0] != 2'b0) err = 1'b1;
         3'd4:             if (lane != 3'd0)      err = 1'b1;
         3'd5, 3'd6, 3'd7: err = 1'b1;
         default: ;
      endcase
   end

   assign finish = reset && (((state_q == ST_IDLE) && req && LAT_ZERO) ||
                             ((state_q == ST_BUSY) && (cnt_q == 4'd0)));
   assign we     = finish && !err && (cur_wr != 3'd0);

   assign word_rd = mem_q[idx];
   assign word_sh = word_rd >> sh;

   always_comb begin
      case (cur_rd)
         3'd1:    load_val = {{56{word_sh[7]}},  word_sh[7:0]};
         3'd2:    load_val = {56'd0,             word_sh[7:0]};
         3'd3:    load_val = {{48{word_sh[15]}}, word_sh[15:0]};
         3'd4:    load_val = {48'd0,             word_sh[15:0]};
         3'd5:    load_val = {{32{word_sh[31]}}, word_sh[31:0]};
         3'd6:    load_val = {32'd0,             word_sh[31:0]};
         3'd7:    load_val = word_rd;
         default: load_val = 64'd0;
      endcase
   end

   always_comb begin
      case (cur_wr)
         3'd1:    mask = 64'h0000_0000_0000_00FF;
         3'd2:    mask = 64'h0000_0000_0000_FFFF;
         3'd3:    mask = 64'h0000_0000_FFFF_FFFF;
         3'd4:    mask = 64'hFFFF_FFFF_FFFF_FFFF;
         default: mask = 64'd0;
      endcase
   end

   assign mask_sh = mask << sh;
   assign word_wr = (word_rd & ~mask_sh) | ((cur_din << sh) & mask_sh);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      din_d   = din_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               addr_d = dram.dram_addr;
               din_d  = dram.dram_din;
               rd_d   = dram.dram_rd_ctrl;
               wr_d   = dram.dram_wr_ctrl;
               if (LAT_ZERO) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_BUSY;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else               state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      valid_d = finish;
      mis_d   = finish && err;
      dout_d  = dout_q;
      if (finish) dout_d = (err || (cur_rd == 3'd0)) ? 64'd0 : load_val;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 64'd0;
         din_q   <= 64'd0;
         rd_q    <= 3'd0;
         wr_q    <= 3'd0;
         dout_q  <= 64'd0;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
      end
   end

   // Storage is deliberately not reset; `we` already excludes cycles held in reset.
   always_ff @(posedge clk) begin
      if (we) mem_q[idx] <= word_wr;
   end

   assign dram.dram_dout       = dout_q;
   assign dram.dram_dout_valid = valid_q;
   assign dram.dram_misalign   = mis_q;
   assign dram.dram_stall_req  = reset && (((state_q == ST_IDLE) && req) || (state_q == ST_BUSY));
endmodule

// File: tb/tb_pipeline_dram_responder7.sv
// Directed bench: a LATENCY=2 responder and a LATENCY=0 responder sharing one stimulus bus.
module tb_pipeline_dram_responder7;
   localparam logic [63:0] BASE = 64'h8000_0000;

   logic        clk;
   logic        reset;
   logic        sel;
   logic [63:0] addr;
   logic [63:0] din;
   logic [2:0]  rd;
   logic [2:0]  wr;
   int          checks;
   int          failures;
   int          cyc;
   int          v_cyc;
   int          v_prev;

   pipeline_dram_responder7_if if_a ();
   pipeline_dram_responder7_if if_b ();

   pipeline_dram_responder7 #(.LATENCY(2)) dut_a (.clk(clk), .reset(reset), .dram(if_a.slave));
   pipeline_dram_responder7 #(.LATENCY(0)) dut_b (.clk(clk), .reset(reset), .dram(if_b.slave));

   assign if_a.dram_addr    = sel ? 64'd0 : addr;
   assign if_a.dram_din     = sel ? 64'd0 : din;
   assign if_a.dram_rd_ctrl = sel ? 3'd0  : rd;
   assign if_a.dram_wr_ctrl = sel ? 3'd0  : wr;
   assign if_b.dram_addr    = sel ? addr : 64'd0;
   assign if_b.dram_din     = sel ? din  : 64'd0;
   assign if_b.dram_rd_ctrl = sel ? rd   : 3'd0;
   assign if_b.dram_wr_ctrl = sel ? wr   : 3'd0;

   logic [63:0] o_dout;
   logic        o_valid, o_stall, o_mis;
   assign o_dout  = sel ? if_b.dram_dout       : if_a.dram_dout;
   assign o_valid = sel ? if_b.dram_dout_valid : if_a.dram_dout_valid;
   assign o_stall = sel ? if_b.dram_stall_req  : if_a.dram_stall_req;
   assign o_mis   = sel ? if_b.dram_misalign   : if_a.dram_misalign;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      assert (obs === exp)
      else begin
         failures = failures + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents one request at a negedge and follows it to its valid pulse.
   task automatic acc(input string tag, input logic [2:0] r, input logic [2:0] w,
                      input logic [63:0] a, input logic [63:0] d, input logic [63:0] exp_dout,
                      input logic exp_mis, input int exp_stall);
      int n;
      logic got;
      rd = r; wr = w; addr = a; din = d;
      n = 0; got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (o_stall) n = n + 1;
         if (o_valid) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      v_cyc = cyc;
      chk({tag, "_valid"}, {63'd0, got}, 64'd1);
      chk({tag, "_stall"}, 64'(n), 64'(exp_stall));
      chk({tag, "_dout"}, o_dout, exp_dout);
      chk({tag, "_mis"}, {63'd0, o_mis}, {63'd0, exp_mis});
      rd = 3'd0; wr = 3'd0; addr = 64'd0; din = 64'd0;
      @(negedge clk);
   endtask

   initial begin
      checks = 0; failures = 0; cyc = 0; v_cyc = 0; v_prev = 0;
      sel = 1'b0; reset = 1'b0;
      addr = BASE; din = 64'd0; rd = 3'd7; wr = 3'd0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_stall", {63'd0, o_stall}, 64'd0);
      chk("rst_dout", o_dout, 64'd0);
      chk("rst_valid", {63'd0, o_valid}, 64'd0);
      rd = 3'd0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("rst_no_valid", {63'd0, o_valid}, 64'd0);
      end
      @(negedge clk);

      acc("sd_base",   3'd0, 3'd4, BASE,     64'h1122_3344_5566_7788, 64'd0, 1'b0, 3);
      acc("ld_base",   3'd7, 3'd0, BASE,     64'd0, 64'h1122_3344_5566_7788, 1'b0, 3);
      acc("sb_3",      3'd0, 3'd1, BASE + 3, 64'h80, 64'd0, 1'b0, 3);
      acc("lb_3",      3'd1, 3'd0, BASE + 3, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3);
      acc("lbu_3",     3'd2, 3'd0, BASE + 3, 64'd0, 64'h80, 1'b0, 3);
      acc("ld_after_sb", 3'd7, 3'd0, BASE,   64'd0, 64'h1122_3344_8066_7788, 1'b0, 3);
      acc("sw_mis",    3'd0, 3'd3, BASE + 2, 64'hDEAD_BEEF, 64'd0, 1'b1, 3);
      acc("ld_after_mis", 3'd7, 3'd0, BASE,  64'd0, 64'h1122_3344_8066_7788, 1'b0, 3);
      acc("sw_4",      3'd0, 3'd3, BASE + 4, 64'h8000_0001, 64'd0, 1'b0, 3);
      acc("lw_4",      3'd5, 3'd0, BASE + 4, 64'd0, 64'hFFFF_FFFF_8000_0001, 1'b0, 3);
      acc("lwu_4",     3'd6, 3'd0, BASE + 4, 64'd0, 64'h0000_0000_8000_0001, 1'b0, 3);
      acc("lh_6",      3'd3, 3'd0, BASE + 6, 64'd0, 64'hFFFF_FFFF_FFFF_8000, 1'b0, 3);
      acc("lhu_2",     3'd4, 3'd0, BASE + 2, 64'd0, 64'h8066, 1'b0, 3);
      acc("lb_0",      3'd1, 3'd0, BASE,     64'd0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 3);
      acc("lh_mis",    3'd3, 3'd0, BASE + 1, 64'd0, 64'd0, 1'b1, 3);
      acc("ld_mis",    3'd7, 3'd0, BASE + 4, 64'd0, 64'd0, 1'b1, 3);
      acc("rdwr_both", 3'd7, 3'd4, BASE,     64'h5555, 64'd0, 1'b1, 3);
      acc("wr_illegal", 3'd0, 3'd5, BASE,    64'h5555, 64'd0, 1'b1, 3);
      acc("ld_intact", 3'd7, 3'd0, BASE,     64'd0, 64'h8000_0001_8066_7788, 1'b0, 3);
      acc("sh_16",     3'd0, 3'd2, BASE + 16, 64'h1234_BEEF, 64'd0, 1'b0, 3);
      acc("lhu_16",    3'd4, 3'd0, BASE + 16, 64'd0, 64'hBEEF, 1'b0, 3);
      acc("lh_16",     3'd3, 3'd0, BASE + 16, 64'd0, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0, 3);
      acc("sd_wrap",   3'd0, 3'd4, BASE + 64'h8000, 64'hCAFE_F00D_1234_5678, 64'd0, 1'b0, 3);
      acc("ld_wrap",   3'd7, 3'd0, BASE,     64'd0, 64'hCAFE_F00D_1234_5678, 1'b0, 3);

      // Abort an SD in flight; the old word must survive.
      acc("sd_8_old",  3'd0, 3'd4, BASE + 8, 64'hA5A5_0000_1111_2222, 64'd0, 1'b0, 3);
      rd = 3'd0; wr = 3'd4; addr = BASE + 8; din = 64'h0BAD_0BAD_0BAD_0BAD;
      @(negedge clk);
      #1;
      chk("abort_busy", {63'd0, o_stall}, 64'd1);
      reset = 1'b0;
      #1;
      chk("abort_stall", {63'd0, o_stall}, 64'd0);
      chk("abort_dout", o_dout, 64'd0);
      wr = 3'd0; addr = 64'd0; din = 64'd0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk("abort_idle_stall", {63'd0, o_stall}, 64'd0);
         chk("abort_idle_valid", {63'd0, o_valid}, 64'd0);
      end
      @(negedge clk);
      acc("ld_8_old",  3'd7, 3'd0, BASE + 8, 64'd0, 64'hA5A5_0000_1111_2222, 1'b0, 3);

      sel = 1'b1;
      @(negedge clk);
      acc("l0_sd",     3'd0, 3'd4, BASE, 64'h0102_0304_0506_0708, 64'd0, 1'b0, 1);
      v_prev = v_cyc;
      acc("l0_ld1",    3'd7, 3'd0, BASE, 64'd0, 64'h0102_0304_0506_0708, 1'b0, 1);
      chk("l0_gap1", 64'(v_cyc - v_prev), 64'd2);
      v_prev = v_cyc;
      acc("l0_sd2",    3'd0, 3'd4, BASE, 64'hFFEE_DDCC_BBAA_9988, 64'd0, 1'b0, 1);
      chk("l0_gap2", 64'(v_cyc - v_prev), 64'd2);
      v_prev = v_cyc;
      acc("l0_ld2",    3'd7, 3'd0, BASE, 64'd0, 64'hFFEE_DDCC_BBAA_9988, 1'b0, 1);
      chk("l0_gap3", 64'(v_cyc - v_prev), 64'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
